// File: rtl/seq_arith_pkg.sv
// Shared arithmetic-datapath definitions for the sequential multiplier and divider.
// Holds the divider state encoding, the default datapath width and a
// two's-complement magnitude helper used by the signed operand path.
package seq_arith_pkg;

  localparam int ARITH_WIDTH = 8;
  // Widest operand the magnitude helper supports.
  localparam int ARITH_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Magnitude of a sign-extended two's-complement value. Callers
  // sign-extend to ARITH_MAX_W and truncate back to their own width.
  // The most-negative value maps onto itself, which reads correctly as an
  // unsigned magnitude after truncation.
  function automatic logic [ARITH_MAX_W-1:0] twos_mag(input logic [ARITH_MAX_W-1:0] v);
    return v[ARITH_MAX_W-1] ? (~v + {{(ARITH_MAX_W-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor when it fits.
// The stored remainder is always below the divisor, so only the shifted
// candidate needs the extra top bit for a safe compare when the divisor MSB=1.
module div_step
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic [WIDTH-1:0] p_i,
  input  logic             d_msb_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] p_o,
  output logic             q_o
);

  logic [WIDTH:0] p_sh;

  // Shift, compare against the zero-extended divisor, conditionally subtract.
  always_comb begin
    p_sh = {p_i, d_msb_i};
    q_o  = (p_sh >= {1'b0, dvsr_i});
    // The true difference is below 2^WIDTH, so a WIDTH-bit subtract is exact.
    p_o  = q_o ? (p_sh[WIDTH-1:0] - dvsr_i) : p_sh[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// start is accepted only in IDLE; results and div_by_zero are held until the
// next completion, with op_ready pulsing for one cycle in DONE.
// Optional: define SEQ_DIVIDER_SIGNED_EN for two's-complement operands
// (magnitudes at capture, truncating-division sign fix-up at completion).
module seq_divider
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             op_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Partial remainder.
  logic [WIDTH-1:0] p_q, p_d;
  // Dividend shifts out of the MSB while quotient bits shift into the LSB;
  // after WIDTH steps this register holds the unsigned quotient.
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_p;
  logic             step_q;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] quo_fin, rem_fin;
  logic             last_step;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  // Core runs on magnitudes; signs are recorded separately at capture.
  always_comb begin
    dvd_mag = WIDTH'(twos_mag(ARITH_MAX_W'($signed(dividend))));
    dvs_mag = WIDTH'(twos_mag(ARITH_MAX_W'($signed(divisor))));
  end
`else
  // Unsigned build: operands feed the core directly.
  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
  end
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_i     (p_q),
    .d_msb_i (d_q[WIDTH-1]),
    .dvsr_i  (dvsr_q),
    .p_o     (step_p),
    .q_o     (step_q)
  );

  // Result of the final step, with sign correction when enabled.
  always_comb begin
    quo_fin   = {d_q[WIDTH-2:0], step_q};
    rem_fin   = step_p;
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (neg_quo_q) quo_fin = -quo_fin;
    if (neg_rem_q) rem_fin = -rem_fin;
`endif
    last_step = (cnt_q == CW'(WIDTH - 1));
  end

  // State and datapath registers; reset clears everything and beats start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      p_q       <= '0;
      d_q       <= '0;
      dvsr_q    <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      d_q       <= d_d;
      dvsr_q    <= dvsr_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  // Next-state, datapath updates and status outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    d_d       = d_q;
    dvsr_d    = dvsr_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    busy      = (state_q != IDLE);
    op_ready  = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = '0;
          p_d   = '0;
          dbz_d = (divisor == '0);
          if (divisor == '0) begin
            // Skip the core: results are defined directly and land in DONE.
            quo_d   = '1;
            rem_d   = dividend;
            state_d = DONE;
          end else begin
            d_d     = dvd_mag;
            dvsr_d  = dvs_mag;
            state_d = RUN;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d = dividend[WIDTH-1];
`endif
          end
        end
      end
      RUN: begin
        p_d   = step_p;
        d_d   = {d_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          // Publish on the last step so results are valid with op_ready.
          quo_d   = quo_fin;
          rem_d   = rem_fin;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results computed
// with plain / and % into a queue; a negedge monitor pops on op_ready.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] dividend, divisor;
  logic         busy, op_ready, div_by_zero;
  logic [W-1:0] quotient, remainder;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .op_ready    (op_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           due;
  } exp_t;

  exp_t scb[$];
  int   errs   = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: quotient/remainder from language arithmetic.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int due);
    exp_t e;
    e.due = due;
    e.dbz = (b == 0);
    if (b == 0) begin
      e.q = '1;
      e.r = a;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      int sa, sb;
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
`else
      e.q = a / b;
      e.r = a % b;
`endif
    end
    return e;
  endfunction

  // Start in the current-next negedge cycle c; DUT must be idle there.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    chk("accept_idle", {31'd0, busy}, 32'd0);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    scb.push_back(model(a, b, cyc + ((b == 0) ? 1 : W + 1)));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (scb.size() == 0 && !busy) break;
    end
    chk("drain_queue", scb.size(), 32'd0);
  endtask

  // Monitor: compare every completion against the oldest expectation.
  logic prev_rdy = 1'b0;
  always @(negedge clk) begin
    if (op_ready) begin
      chk("ready_not_back_to_back", {31'd0, prev_rdy}, 32'd0);
      if (scb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_op_ready: got op_ready=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = scb.pop_front();
        chk("ready_cycle", cyc, e.due);
        chk("quotient", {24'd0, quotient}, {24'd0, e.q});
        chk("remainder", {24'd0, remainder}, {24'd0, e.r});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
      end
    end
    prev_rdy <= op_ready;
  end

  initial begin
    logic [W-1:0] a, b;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_op_ready", {31'd0, op_ready}, 32'd0);
    chk("rst_quotient", {24'd0, quotient}, 32'd0);
    chk("rst_remainder", {24'd0, remainder}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;

    // 100/7 with busy profile: high for cycles 1..W+1, low at W+2.
    issue(8'd100, 8'd7);
    for (int k = 1; k <= W + 2; k++) begin
      chk($sformatf("busy_c%0d", k), {31'd0, busy}, (k <= W + 1) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    wait_drain();

    // Divide by zero, then a normal op clears the flag at accept.
    issue(8'd5, 8'd0);
    wait_drain();
    chk("dbz_held", {31'd0, div_by_zero}, 32'd1);
    issue(8'd9, 8'd3);
    chk("dbz_clear_on_accept", {31'd0, div_by_zero}, 32'd0);
    wait_drain();

    // Start pulses while busy must be ignored.
    issue(8'd200, 8'd13);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start    = 1'b1;
      dividend = W'(50 + i);
      divisor  = 8'd5;
    end
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Reset in cycle 4 of an operation aborts it silently.
    @(negedge clk);
    dividend = 8'd255; divisor = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_quotient", {24'd0, quotient}, 32'd0);
    chk("abort_remainder", {24'd0, remainder}, 32'd0);
    chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (W + 3) @(negedge clk);
    issue(8'd255, 8'd1);
    wait_drain();

    // Boundaries, issued back to back at W+2 spacing.
    issue(8'd3, 8'd200);
    repeat (W) @(negedge clk);
    issue(8'd255, 8'd128);
    repeat (W) @(negedge clk);
    issue(8'd0, 8'd1);
    wait_drain();

`ifdef SEQ_DIVIDER_SIGNED_EN
    issue(8'hF9, 8'd2);
    wait_drain();
    issue(8'd7, 8'hFE);
    wait_drain();
    issue(8'h80, 8'hFF);
    wait_drain();
    issue(8'h80, 8'd0);
    wait_drain();
`endif

    // Random operations with random idle gaps, including zero divisors.
    for (int n = 0; n < 60; n++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      issue(a, b);
      repeat (((b == 0) ? 0 : W) + $urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring divider; the inverse operation of the team's shift-add sequential multiplier.
- Produces one quotient bit per clock.
- Sits in the same arithmetic datapath and uses the same op_ready completion convention as the multiplier.
- Accepts one operation per start pulse. Results are held until the next operation is accepted.

Parameters:
- WIDTH, 8, operand/result width in bits (must be >= 2).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- dividend  input  WIDTH  numerator; captured on accepted start.
- divisor  input  WIDTH  denominator; captured on accepted start.
- busy  output  1  high while an operation is in flight (state != IDLE).
- op_ready  output  1  single-cycle pulse when quotient/remainder become valid.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  set with op_ready when the captured divisor was 0; held with results.

Behaviour:
- Reset (rst=1 at posedge, any state): state=IDLE, busy=0, op_ready=0, quotient=0, remainder=0, div_by_zero=0, internal registers cleared. Reset overrides start.
- An in-flight operation aborted by reset produces no op_ready.
- States: IDLE, RUN, DONE; encoded as an enum.
- IDLE: start=1 captures the operands.
  - Divisor != 0: load dividend shift register, partial remainder P (WIDTH+1 bits) = 0, count = 0; go to RUN.
  - Divisor == 0: go to DONE directly.
- RUN, one step per cycle:
  - P' = {P[WIDTH-1:0], D[WIDTH-1]}; D shifts left.
  - If P' >= {1'b0, divisor}: P = P' - divisor, shift 1 into the quotient LSB.
  - Otherwise: P = P', shift 0 into the quotient LSB.
  - After WIDTH steps (count = WIDTH-1 on the last step), go to DONE.
- DONE (one cycle): op_ready=1; quotient/remainder/div_by_zero registered outputs updated the same cycle. Next cycle goes to IDLE.
- Latency: start high in cycle 0 gives RUN in cycles 1..WIDTH and op_ready in cycle WIDTH+1. busy is high for cycles 1..WIDTH+1. Next start is accepted in cycle WIDTH+2.
- Divide by zero: op_ready in cycle 1; quotient = all ones; remainder = dividend; div_by_zero=1.
- div_by_zero is cleared on the next accepted start.
- start while busy=1 is ignored (not queued); operand changes while busy have no effect.
- Outputs are stable between op_ready pulses. op_ready is never high for two consecutive cycles.
- Width rules: the unsigned remainder is always < divisor. The (WIDTH+1)-bit P prevents compare overflow when divisor MSB=1.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined: operands are two's complement.
  - Magnitudes are taken at capture; the core runs unsigned.
  - In DONE: quotient is negated if the operand signs differ; remainder takes the dividend's sign (truncating division).
  - Latency is unchanged.
  - Most-negative / -1 wraps: quotient = most-negative, remainder = 0.
  - Divide by zero: quotient = all ones (-1), remainder = dividend.
- Undefined: unsigned only; no sign logic synthesized.

Decomposition:
- Package seq_arith_pkg (shared with the multiplier):
  - state enum div_state_t {IDLE, RUN, DONE}.
  - Default width constant ARITH_WIDTH=8.
  - Helper function for two's-complement magnitude.
- One sub-module, div_step: a combinational single restoring step.
  - Inputs: P, next dividend bit, divisor.
  - Outputs: new P, quotient bit.
  - Keeps the FSM module focused on control and counting.

Test Plan:
- WIDTH=8, 100/7, start in cycle 0 -> busy cycles 1-9; op_ready only in cycle 9; quotient=14, remainder=2, div_by_zero=0.
- 5/0 -> op_ready in cycle 1; quotient=0xFF, remainder=5, div_by_zero=1; a following 9/3 -> quotient=3, remainder=0, div_by_zero=0.
- 200/13 started, then start=1 with 50/5 during cycles 3-6 -> ignored; result quotient=15, remainder=5; single op_ready.
- rst asserted in cycle 4 of 255/1 -> all outputs 0 next cycle, no op_ready; new 255/1 -> quotient=255, remainder=0.
- Boundaries: 3/200 -> quotient=0, remainder=3; 255/128 -> quotient=1, remainder=127; back-to-back starts accepted at cycle WIDTH+2 spacing.
- SEQ_DIVIDER_SIGNED_EN defined: -7/2 -> quotient=0xFD (-3), remainder=0xFF (-1); 7/-2 -> quotient=0xFD, remainder=1; -128/-1 -> quotient=0x80, remainder=0.
